// File: rtl/csr_file.sv
// csr_file: architectural CSR storage for the LA32 core.
// Holds the CSR state. It takes writes from the exception unit and from CSR instructions,
// and it runs the stable timer that drives the timer interrupt.

package csr_pkg;

   typedef struct packed {
      logic [31:0] crmd;
      logic [31:0] prmd;
      logic [31:0] ecfg;
      logic [31:0] estat;
      logic [31:0] era;
      logic [31:0] badv;
      logic [31:0] eentry;
      logic [31:0] tlbrentry;
      logic [31:0] save0;
      logic [31:0] save1;
      logic [31:0] save2;
      logic [31:0] save3;
      logic [31:0] tid;
      logic [31:0] tcfg;
      logic [31:0] tval;
      logic [31:0] ticlr;
   } csr_t;

   typedef struct packed {
      logic        we;
      logic [31:0] crmd;
      logic [31:0] prmd;
      logic [31:0] estat;
      logic [31:0] era;
      logic [31:0] badv;
   } excp_wr_csr_req_t;

   localparam logic [13:0] CsrCrmd      = 14'h0;
   localparam logic [13:0] CsrPrmd      = 14'h1;
   localparam logic [13:0] CsrEcfg      = 14'h4;
   localparam logic [13:0] CsrEstat     = 14'h5;
   localparam logic [13:0] CsrEra       = 14'h6;
   localparam logic [13:0] CsrBadv      = 14'h7;
   localparam logic [13:0] CsrEentry    = 14'hC;
   localparam logic [13:0] CsrSave0     = 14'h30;
   localparam logic [13:0] CsrSave1     = 14'h31;
   localparam logic [13:0] CsrSave2     = 14'h32;
   localparam logic [13:0] CsrSave3     = 14'h33;
   localparam logic [13:0] CsrTid       = 14'h40;
   localparam logic [13:0] CsrTcfg      = 14'h41;
   localparam logic [13:0] CsrTval      = 14'h42;
   localparam logic [13:0] CsrTiclr     = 14'h44;
   localparam logic [13:0] CsrTlbrentry = 14'h88;

endpackage

module csr_file
   import csr_pkg::*;
#(
   parameter logic [31:0] CORE_ID = 32'h0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       hwi_in,
   input  excp_wr_csr_req_t excp_req,
   input  logic             inst_csr_we,
   input  logic [13:0]      inst_csr_addr,
   input  logic [31:0]      inst_csr_wdata,
   input  logic [31:0]      inst_csr_wmask,
   output logic [31:0]      inst_csr_rdata,
   output csr_t             rd_csr,
   output logic             ti_out
);

   localparam logic [31:0] CrmdMask  = 32'h0000_01FF;
   localparam logic [31:0] PrmdMask  = 32'h0000_0007;
   localparam logic [31:0] EcfgMask  = 32'h0000_1BFF;
   localparam logic [31:0] EntryMask = 32'hFFFF_FFC0;

   csr_t        csr_q, csr_d;
   logic        armed_q, armed_d;
   logic [31:0] wr_val;
   logic        ticlr_clr;
   logic        timer_fire;

   // ESTAT bits the exception unit never supplies are deliberately ignored.
   logic unused_excp_estat;
   assign unused_excp_estat = ^{excp_req.estat[31], excp_req.estat[15:2]};

   // Combinational read port; TICLR and unmapped numbers read as zero.
   always_comb begin
      inst_csr_rdata = '0;
      case (inst_csr_addr)
         CsrCrmd:      inst_csr_rdata = csr_q.crmd;
         CsrPrmd:      inst_csr_rdata = csr_q.prmd;
         CsrEcfg:      inst_csr_rdata = csr_q.ecfg;
         CsrEstat:     inst_csr_rdata = csr_q.estat;
         CsrEra:       inst_csr_rdata = csr_q.era;
         CsrBadv:      inst_csr_rdata = csr_q.badv;
         CsrEentry:    inst_csr_rdata = csr_q.eentry;
         CsrSave0:     inst_csr_rdata = csr_q.save0;
         CsrSave1:     inst_csr_rdata = csr_q.save1;
         CsrSave2:     inst_csr_rdata = csr_q.save2;
         CsrSave3:     inst_csr_rdata = csr_q.save3;
         CsrTid:       inst_csr_rdata = csr_q.tid;
         CsrTcfg:      inst_csr_rdata = csr_q.tcfg;
         CsrTval:      inst_csr_rdata = csr_q.tval;
         CsrTlbrentry: inst_csr_rdata = csr_q.tlbrentry;
         default:      inst_csr_rdata = '0;
      endcase
   end

   // Next-state: timer tick, then exception or instruction write, then hardware IS bits.
   always_comb begin
      csr_d      = csr_q;
      armed_d    = armed_q;
      ticlr_clr  = 1'b0;
      timer_fire = 1'b0;
      // Masked merge against the current value; TICLR's old value is zero.
      wr_val     = (inst_csr_rdata & ~inst_csr_wmask) | (inst_csr_wdata & inst_csr_wmask);

      if (armed_q) begin
         if (csr_q.tval != 32'h0) begin
            csr_d.tval = csr_q.tval - 32'h1;
         end else begin
            timer_fire = 1'b1;
            if (csr_q.tcfg[1]) begin
               csr_d.tval = {csr_q.tcfg[31:2], 2'b00};
            end else begin
               csr_d.tval = 32'hFFFF_FFFF;
               armed_d    = 1'b0;
            end
         end
      end

      if (excp_req.we) begin
         // The exception update takes priority, and the instruction write is dropped.
         csr_d.crmd         = excp_req.crmd;
         csr_d.prmd         = excp_req.prmd;
         csr_d.era          = excp_req.era;
         csr_d.badv         = excp_req.badv;
         csr_d.estat[30:16] = excp_req.estat[30:16];
         csr_d.estat[1:0]   = excp_req.estat[1:0];
      end else if (inst_csr_we) begin
         case (inst_csr_addr)
            CsrCrmd:      csr_d.crmd       = wr_val & CrmdMask;
            CsrPrmd:      csr_d.prmd       = wr_val & PrmdMask;
            CsrEcfg:      csr_d.ecfg       = wr_val & EcfgMask;
            CsrEstat:     csr_d.estat[1:0] = wr_val[1:0];
            CsrEra:       csr_d.era        = wr_val;
            CsrBadv:      csr_d.badv       = wr_val;
            CsrEentry:    csr_d.eentry     = wr_val & EntryMask;
            CsrSave0:     csr_d.save0      = wr_val;
            CsrSave1:     csr_d.save1      = wr_val;
            CsrSave2:     csr_d.save2      = wr_val;
            CsrSave3:     csr_d.save3      = wr_val;
            CsrTid:       csr_d.tid        = wr_val;
            CsrTlbrentry: csr_d.tlbrentry  = wr_val & EntryMask;
            CsrTcfg: begin
               csr_d.tcfg = wr_val;
               csr_d.tval = {wr_val[31:2], 2'b00};
               armed_d    = wr_val[0];
            end
            CsrTiclr:     ticlr_clr        = wr_val[0];
            default:      ;
         endcase
      end

      csr_d.estat[9:2] = hwi_in;
      if (ticlr_clr) begin
         csr_d.estat[11] = 1'b0;
      end
      // A timer expiry in the same cycle as a clear leaves the interrupt pending.
      if (timer_fire) begin
         csr_d.estat[11] = 1'b1;
      end
      csr_d.ticlr = '0;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         csr_q      <= '0;
         csr_q.crmd <= 32'h0000_0008;
         csr_q.tid  <= CORE_ID;
         armed_q    <= 1'b0;
      end else begin
         csr_q   <= csr_d;
         armed_q <= armed_d;
      end
   end

   assign rd_csr = csr_q;
   assign ti_out = csr_q.estat[11];

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: scoreboard bench for csr_file covering reads, writes, exceptions and the timer.
module tb_csr_file;
   import csr_pkg::*;

   localparam logic [31:0] CoreId = 32'h0000_00A5;

   logic             clk;
   logic             rst;
   logic [7:0]       hwi_in;
   excp_wr_csr_req_t excp_req;
   logic             inst_csr_we;
   logic [13:0]      inst_csr_addr;
   logic [31:0]      inst_csr_wdata;
   logic [31:0]      inst_csr_wmask;
   logic [31:0]      inst_csr_rdata;
   csr_t             rd_csr;
   logic             ti_out;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   csr_file #(.CORE_ID(CoreId)) dut (
      .clk            (clk),
      .rst            (rst),
      .hwi_in         (hwi_in),
      .excp_req       (excp_req),
      .inst_csr_we    (inst_csr_we),
      .inst_csr_addr  (inst_csr_addr),
      .inst_csr_wdata (inst_csr_wdata),
      .inst_csr_wmask (inst_csr_wmask),
      .inst_csr_rdata (inst_csr_rdata),
      .rd_csr         (rd_csr),
      .ti_out         (ti_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   // Queue the expectation, present the address, compare at the following negedge.
   task automatic rd_expect(input string tag, input logic [13:0] addr, input logic [31:0] exp);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      inst_csr_addr = addr;
      @(negedge clk);
      check(tag_q.pop_front(), inst_csr_rdata, exp_q.pop_front());
   endtask

   // Instruction write; starts and ends on a negedge, one clock edge in between.
   task automatic wr(input logic [13:0] addr, input logic [31:0] data, input logic [31:0] mask);
      inst_csr_we    = 1'b1;
      inst_csr_addr  = addr;
      inst_csr_wdata = data;
      inst_csr_wmask = mask;
      @(posedge clk);
      #1;
      inst_csr_we = 1'b0;
      @(negedge clk);
   endtask

   task automatic excp(input logic [31:0] crmd, input logic [31:0] prmd, input logic [31:0] estat,
                       input logic [31:0] era, input logic [31:0] badv, input logic with_inst);
      excp_req.we    = 1'b1;
      excp_req.crmd  = crmd;
      excp_req.prmd  = prmd;
      excp_req.estat = estat;
      excp_req.era   = era;
      excp_req.badv  = badv;
      if (with_inst) begin
         inst_csr_we    = 1'b1;
         inst_csr_addr  = CsrEra;
         inst_csr_wdata = 32'h0000_DEAD;
         inst_csr_wmask = 32'hFFFF_FFFF;
      end
      @(posedge clk);
      #1;
      excp_req.we = 1'b0;
      inst_csr_we = 1'b0;
      @(negedge clk);
   endtask

   logic [13:0] addrs [20] = '{14'h0, 14'h1, 14'h4, 14'h5, 14'h6, 14'h7, 14'hC, 14'h30, 14'h31,
                               14'h32, 14'h33, 14'h40, 14'h41, 14'h42, 14'h44, 14'h88, 14'h2,
                               14'h3, 14'h43, 14'h100};

   initial begin
      rst            = 1'b1;
      hwi_in         = '0;
      excp_req       = '0;
      inst_csr_we    = 1'b0;
      inst_csr_addr  = '0;
      inst_csr_wdata = '0;
      inst_csr_wmask = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state across the address map.
      check("rst_ti", {31'b0, ti_out}, 32'h0);
      check("rst_estat", rd_csr.estat, 32'h0);
      for (int i = 0; i < 20; i++) begin
         logic [31:0] e;
         e = (addrs[i] == CsrCrmd) ? 32'h8 : (addrs[i] == CsrTid) ? CoreId : 32'h0;
         rd_expect($sformatf("rst_rd_%0h", addrs[i]), addrs[i], e);
      end

      // Writable-field restriction and ignored writes.
      wr(CsrCrmd, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      rd_expect("crmd_mask", CsrCrmd, 32'h0000_01FF);
      wr(CsrPrmd, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      rd_expect("prmd_mask", CsrPrmd, 32'h0000_0007);
      wr(CsrEcfg, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      rd_expect("ecfg_mask", CsrEcfg, 32'h0000_1BFF);
      wr(CsrEentry, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      rd_expect("eentry_mask", CsrEentry, 32'hFFFF_FFC0);
      wr(CsrTlbrentry, 32'h1234_5678, 32'hFFFF_FFFF);
      rd_expect("tlbr_mask", CsrTlbrentry, 32'h1234_5640);
      wr(CsrEstat, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      rd_expect("estat_sw", CsrEstat, 32'h0000_0003);
      wr(CsrTval, 32'h1234, 32'hFFFF_FFFF);
      rd_expect("tval_ro", CsrTval, 32'h0);
      wr(14'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      rd_expect("unmapped", 14'h3, 32'h0);

      // csrxchg on SAVE0: old value visible in the write cycle, merged value after.
      wr(CsrSave0, 32'hFFFF_0000, 32'hFFFF_FFFF);
      inst_csr_we    = 1'b1;
      inst_csr_addr  = CsrSave0;
      inst_csr_wdata = 32'h1234_5678;
      inst_csr_wmask = 32'h0000_FFFF;
      #1;
      check("xchg_same_cycle", inst_csr_rdata, 32'hFFFF_0000);
      @(posedge clk);
      #1;
      inst_csr_we = 1'b0;
      rd_expect("xchg_next", CsrSave0, 32'hFFFF_5678);

      // Exception beats a same-cycle instruction write to ERA.
      excp(32'h0, 32'h6, 32'h0048_0002, 32'h1C00_0100, 32'h0000_BAD0, 1'b1);
      check("excp_era", rd_csr.era, 32'h1C00_0100);
      check("excp_prmd", rd_csr.prmd, 32'h6);
      check("excp_crmd", rd_csr.crmd, 32'h0);
      check("excp_badv", rd_csr.badv, 32'h0000_BAD0);
      check("excp_estat", rd_csr.estat, 32'h0048_0002);

      // Eret restores PLV=3, IE=1.
      excp(32'h7, 32'h6, 32'h0048_0002, 32'h1C00_0100, 32'h0000_BAD0, 1'b0);
      check("eret_plv", {30'b0, rd_csr.crmd[1:0]}, 32'h3);
      check("eret_ie", {31'b0, rd_csr.crmd[2]}, 32'h1);
      check("eret_era", rd_csr.era, 32'h1C00_0100);

      // Hardware interrupt sampling: one cycle latency.
      hwi_in = 8'h81;
      #1;
      check("hwi_before", {24'b0, rd_csr.estat[9:2]}, 32'h0);
      @(negedge clk);
      check("hwi_after", {24'b0, rd_csr.estat[9:2]}, 32'h81);
      hwi_in = 8'h00;
      @(negedge clk);

      // One-shot timer: initval 2 loads TVAL=8.
      wr(CsrTcfg, 32'h0000_0009, 32'hFFFF_FFFF);
      for (int i = 0; i < 12; i++) begin
         check($sformatf("oneshot_tval_%0d", i), rd_csr.tval,
               (i <= 8) ? 32'(8 - i) : 32'hFFFF_FFFF);
         check($sformatf("oneshot_ti_%0d", i), {31'b0, ti_out}, (i >= 9) ? 32'h1 : 32'h0);
         @(negedge clk);
      end
      wr(CsrTiclr, 32'h1, 32'hFFFF_FFFF);
      check("ticlr_ti", {31'b0, ti_out}, 32'h0);
      rd_expect("ticlr_rd", CsrTiclr, 32'h0);

      // Periodic timer: initval 1 reloads TVAL=4.
      wr(CsrTcfg, 32'h0000_0007, 32'hFFFF_FFFF);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("per_tval_%0d", i), rd_csr.tval, 32'(4 - i));
         check($sformatf("per_ti_%0d", i), {31'b0, ti_out}, 32'h0);
         @(negedge clk);
      end
      check("per_reload", rd_csr.tval, 32'h4);
      check("per_fire", {31'b0, ti_out}, 32'h1);
      wr(CsrTiclr, 32'h1, 32'hFFFF_FFFF);
      check("per_clr_tval", rd_csr.tval, 32'h3);
      check("per_clr_ti", {31'b0, ti_out}, 32'h0);
      repeat (3) @(negedge clk);
      check("per_zero", rd_csr.tval, 32'h0);
      // Clear on the expiry cycle: the set wins.
      wr(CsrTiclr, 32'h1, 32'hFFFF_FFFF);
      check("clr_vs_set_tval", rd_csr.tval, 32'h4);
      check("clr_vs_set_ti", {31'b0, ti_out}, 32'h1);

      // Reset while counting with an interrupt pending.
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_tval", rd_csr.tval, 32'h0);
      check("midrst_ti", {31'b0, ti_out}, 32'h0);
      check("midrst_crmd", rd_csr.crmd, 32'h8);
      repeat (3) @(negedge clk);
      check("midrst_hold", rd_csr.tval, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Architectural CSR storage for the LA32 core: CRMD, PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, TLBRENTRY, SAVE0-3, TID, TCFG, TVAL, TICLR.
- Two write sources:
  - The exception unit at writeback supplies a whole-state update request (excp_wr_csr_req_t).
  - CSR instructions (csrrd/csrwr/csrxchg) write through an addressed, masked port.
- Exports the full register state as csr_t, owns the stable timer, and produces the timer interrupt line.

Parameters:
- CORE_ID, 32'h0, reset value of TID.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- hwi_in  in  8  hardware interrupt levels, sampled into ESTAT.IS[9:2]
- excp_req  in  excp_wr_csr_req_t  exception/eret update; .we qualifies
- inst_csr_we  in  1  instruction write strobe
- inst_csr_addr  in  14  CSR number (shared by read and write)
- inst_csr_wdata  in  32  write data
- inst_csr_wmask  in  32  bit mask; csrwr drives all-ones
- inst_csr_rdata  out  32  combinational read of inst_csr_addr
- rd_csr  out  csr_t  registered state of all CSRs
- ti_out  out  1  timer interrupt pending (= ESTAT.IS[11])

Behaviour:

Reset (rst=1 at posedge):
- CRMD=32'h8 (DA=1, PLV=0, IE=0).
- TID=CORE_ID.
- All other CSRs=0; timer disarmed.
- Outputs follow from the register values.

Address map:
- CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC
- SAVE0-3 0x30-0x33, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44, TLBRENTRY 0x88
- Unmapped addresses: read 0, writes ignored.

Instruction writes (applied at posedge; new value = (old & ~wmask) | (wdata & wmask), then restricted to the writable field):
- CRMD[8:0], PRMD[2:0].
- ECFG {[12:11],[9:0]}.
- ESTAT[1:0] only.
- ERA, BADV, SAVE*, TID: 32 bits.
- EENTRY/TLBRENTRY [31:6].
- TCFG [31:0].
- TVAL: read-only.
- TICLR: reads 0; writing bit0=1 clears ESTAT.IS[11].

Reads:
- inst_csr_rdata is combinational from current registers.
- A write becomes visible the next cycle; no bypass.

Exception requests (excp_req.we=1):
- Load CRMD, PRMD, ERA, BADV from the request.
- Load ESTAT: esubcode/ecode and IS[1:0] from the request; IS[12:2] stay hardware-owned.

Simultaneous sources:
- excp_req.we and inst_csr_we in the same cycle: the exception update wins and the instruction write is dropped entirely.

ESTAT.IS[9:2]:
- Registered copy of hwi_in every cycle; 1-cycle latency.

Timer:
- A write to TCFG loads TVAL={new_initval[31:2],2'b00} and sets armed=new TCFG[0].
- While armed and TVAL!=0: TVAL decrements by 1 per cycle.
- While armed and TVAL==0:
  - Set ESTAT.IS[11].
  - Periodic (TCFG[1]=1): reload TVAL={initval,2'b00}.
  - Otherwise: TVAL becomes 32'hFFFF_FFFF and armed clears.
- TCFG[0]=0: TVAL holds.
- Timer set and TICLR clear in the same cycle: set wins.
- Initval 0 in periodic mode: the timer fires every cycle.

ti_out:
- Equals ESTAT.IS[11] combinationally from the register; 0 after reset.

Reset mid-count:
- Disarms the timer, zeroes TVAL and clears a pending IS[11] on that edge.

Test Plan:
- Reset → CRMD=0x8, TID=CORE_ID, ESTAT=0, ti_out=0, inst_csr_rdata=0 at every address.
- csrxchg SAVE0: SAVE0=0xFFFF0000, wdata=0x1234_5678, wmask=0x0000_FFFF → next cycle reads 0xFFFF5678; same-cycle read still returns 0xFFFF0000.
- Exception and instruction write in the same cycle:
  - Stimulus: excp_req.we=1 (crmd.plv=0, ie=0, era=0x1C00_0100) together with an inst write of ERA=0xDEAD.
  - Required: ERA=0x1C00_0100, PRMD takes the request value.
- Eret request restoring PLV=3, IE=1 → CRMD.plv=3, CRMD.ie=1, ERA unchanged.
- One-shot timer:
  - Stimulus: TCFG=0x0000_0009 (initval=2, en=1, one-shot).
  - Required: TVAL goes 8,7,…,0; ti_out rises the cycle after TVAL=0; TVAL then stays 0xFFFF_FFFF.
  - Follow-up: TICLR write with bit0=1 → ti_out=0.
- Periodic timer and interrupt sampling:
  - Periodic timer with TCFG=0x0000_0007 → TVAL reloads to 4 after each expiry.
  - TICLR written on an expiry cycle → IS[11] stays 1.
  - hwi_in=0x81 → ESTAT.IS[9:2]=0x81 one cycle later.
